// File: rtl/mpu_gate.sv
// mpu_gate: memory protection stage between the CPU native bus and SRAM.
// Each access is checked against base/limit/attr regions; denied ones fault locally.
module mpu_gate #(
  parameter int NREGIONS     = 4,
  parameter bit RESET_ENABLE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  input  logic        cpu_instr,
  output logic        cpu_ready,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic [31:0] cpu_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        cfg_enop,
  input  logic [7:0]  cfg_op,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        fault,
  output logic        fault_irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FWD,
    S_DONE,
    S_FAULT
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;
  logic [31:0] rdata_q;

  logic [31:0] base_q  [NREGIONS];
  logic [31:0] limit_q [NREGIONS];
  logic [31:0] attr_q  [NREGIONS];
  logic        enable_q;

  logic        fault_q;
  logic [31:0] fault_addr_q;
  logic [4:0]  fault_info_q;
  logic [31:0] cfg_rdata_q;

  logic [3:0]  cfg_opc;
  logic [3:0]  cfg_idx;
  logic        fault_clr;

  assign cfg_opc   = cfg_op[7:4];
  assign cfg_idx   = cfg_op[3:0];
  assign fault_clr = cfg_enop && (cfg_opc == 4'hA);

  logic is_w;
  logic is_x;
  logic is_r;
  logic grant;
  logic permit;

  assign is_w = |wstrb_q;
  assign is_x = !is_w && instr_q;
  assign is_r = !is_w && !instr_q;

  // Overlapping regions OR their grants together.
  always_comb begin
    grant = 1'b0;
    for (int i = 0; i < NREGIONS; i++) begin
      if (attr_q[i][31] &&
          (base_q[i] <= addr_q) &&
          (addr_q < limit_q[i])) begin
        if ((is_r && attr_q[i][0]) ||
            (is_w && attr_q[i][1]) ||
            (is_x && attr_q[i][2]))
          grant = 1'b1;
      end
    end
  end

  assign permit = !enable_q || grant;

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    fault_irq = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_valid)
          state_d = S_CHECK;
      end
      S_CHECK: begin
        state_d = permit ? S_FWD : S_FAULT;
      end
      S_FWD: begin
        mem_valid = 1'b1;
        mem_instr = instr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
        if (mem_ready)
          state_d = S_DONE;
      end
      S_DONE: begin
        cpu_ready = 1'b1;
        cpu_rdata = rdata_q;
        state_d   = S_IDLE;
      end
      S_FAULT: begin
        cpu_ready = 1'b1;
        fault_irq = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cpu_valid) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        wstrb_q <= cpu_wstrb;
        instr_q <= cpu_instr;
      end
      if (state_q == S_FWD && mem_ready)
        rdata_q <= mem_rdata;
    end
  end

  // Clear takes priority over a fault completing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      fault_info_q <= '0;
    end else if (fault_clr) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      fault_info_q <= '0;
    end else if (state_q == S_FAULT && !fault_q) begin
      fault_q      <= 1'b1;
      fault_addr_q <= addr_q;
      fault_info_q <= {instr_q, wstrb_q};
    end
  end

  assign fault = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= RESET_ENABLE;
      for (int i = 0; i < NREGIONS; i++) begin
        base_q[i]  <= '0;
        limit_q[i] <= '0;
        attr_q[i]  <= '0;
      end
    end else if (cfg_enop) begin
      if (cfg_opc == 4'h9)
        enable_q <= cfg_wdata[0];
      for (int i = 0; i < NREGIONS; i++) begin
        if (cfg_idx == 4'(i)) begin
          if (cfg_opc == 4'h1) base_q[i]  <= cfg_wdata;
          if (cfg_opc == 4'h2) limit_q[i] <= cfg_wdata;
          if (cfg_opc == 4'h3) attr_q[i]  <= cfg_wdata;
        end
      end
    end
  end

  logic [31:0] sel_base;
  logic [31:0] sel_limit;
  logic [31:0] sel_attr;

  // Out-of-range indices match nothing and read back as zero.
  always_comb begin
    sel_base  = '0;
    sel_limit = '0;
    sel_attr  = '0;
    for (int i = 0; i < NREGIONS; i++) begin
      if (cfg_idx == 4'(i)) begin
        sel_base  = base_q[i];
        sel_limit = limit_q[i];
        sel_attr  = attr_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_rdata_q <= '0;
    end else if (cfg_enop) begin
      case (cfg_opc)
        4'h1, 4'h2, 4'h3,
        4'h9, 4'hA: cfg_rdata_q <= cfg_rdata_q;
        4'h4: cfg_rdata_q <= sel_base;
        4'h5: cfg_rdata_q <= sel_limit;
        4'h6: cfg_rdata_q <= sel_attr;
        4'h7: cfg_rdata_q <= fault_addr_q;
        4'h8: cfg_rdata_q <= {26'd0, fault_info_q, fault_q};
        default: cfg_rdata_q <= '0;
      endcase
    end
  end

  assign cfg_rdata = cfg_rdata_q;

endmodule

// File: doc/mpu_gate.md
Name: mpu_gate

Overview:
Memory protection stage between the picorv32 native memory bus (upstream) and internal SRAM/memory bus (downstream).
- Checks every CPU transaction against NREGIONS programmable base/limit/attribute regions.
- Forwards permitted transactions unchanged; completes denied ones locally and latches a fault.
- Region registers are programmed over the core's enop/op/wdata/rdata side-channel, the same style as the safe_region port.

Parameters:
NREGIONS, 4, number of protection regions (1..16).
RESET_ENABLE, 0, value of the global enable bit after reset.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset (top drives it from !resetn)
cpu_valid  in  1  upstream request valid; held until cpu_ready
cpu_instr  in  1  request is an instruction fetch
cpu_ready  out  1  one-cycle completion pulse to CPU
cpu_addr  in  32  request byte address
cpu_wdata  in  32  write data
cpu_wstrb  in  4  byte write enables; 0 = read
cpu_rdata  out  32  read data returned with cpu_ready
mem_valid  out  1  downstream request valid
mem_instr  out  1  forwarded cpu_instr
mem_ready  in  1  downstream completion
mem_addr  out  32  forwarded address
mem_wdata  out  32  forwarded write data
mem_wstrb  out  4  forwarded strobes
mem_rdata  in  32  downstream read data
cfg_enop  in  1  config operation strobe
cfg_op  in  8  [7:4] opcode, [3:0] region index
cfg_wdata  in  32  config write data
cfg_rdata  out  32  config read data, registered
fault  out  1  sticky fault flag
fault_irq  out  1  one-cycle pulse on each denied access

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - All region base/limit/attr = 0 (invalid); global enable = RESET_ENABLE.
  - fault_addr = 0, fault_info = 0.
- Reset mid-transaction: mem_valid drops the next cycle. No cpu_ready is issued.
- Access type:
  - wstrb != 0 -> W.
  - wstrb == 0 and cpu_instr -> X.
  - Otherwise -> R.
- Region attr bits: [0] R, [1] W, [2] X, [31] V.
- Region match: V && base <= addr && addr < limit. Unsigned 32-bit compare; limit is exclusive; base >= limit never matches.
- Permit rule: global enable == 0, OR any matching region grants the access type. Overlapping regions OR their grants.
- FSM:
  - IDLE: on cpu_valid, capture addr/wdata/wstrb/instr -> CHECK.
  - CHECK: evaluate regions from register values in this cycle. Permitted -> FWD; denied -> FAULT.
  - FWD: mem_valid=1, mem_* = captured values. On mem_ready, capture mem_rdata and drop mem_valid -> DONE.
  - DONE: cpu_ready=1, cpu_rdata=captured data -> IDLE.
  - FAULT: cpu_ready=1, cpu_rdata=0, fault_irq=1, no downstream access -> IDLE.
    - If fault was 0: set fault, latch fault_addr and fault_info={instr, wstrb}.
    - Later faults do not overwrite these.
- Latency: with mem_ready one cycle after mem_valid, cpu_ready is asserted 4 cycles after cpu_valid is first sampled. A denied access completes in 2 cycles.
- cpu_valid is ignored outside IDLE. A new request is accepted in the cycle after cpu_ready.
- Config ops (when cfg_enop=1):
  - 0x1 write base[idx]; 0x2 write limit[idx]; 0x3 write attr[idx].
  - 0x4/0x5/0x6 read base/limit/attr[idx].
  - 0x7 read fault_addr; 0x8 read {fault_info[4:0], fault} in the low bits.
  - 0x9 write ctrl (wdata[0] = global enable); 0xA clear fault (fault, fault_addr, fault_info -> 0).
  - Other opcodes: no-op, cfg_rdata=0.
- Config timing:
  - Writes take effect the cycle after cfg_enop.
  - A write coinciding with CHECK does not affect that check.
  - Reads: cfg_rdata valid the cycle after cfg_enop; held until the next read op.
  - idx >= NREGIONS: writes ignored, reads return 0.
- Config op 0xA coinciding with a FAULT completion: clear wins; fault is set on the following fault only.

Test Plan:
- Reset, enable=0: CPU read at 0x10, sram word 0x12345678 -> forwarded; cpu_ready 4 cycles later with cpu_rdata=0x12345678; fault=0.
- Region0 base=0, limit=0x400, attr=0x80000005 (V,R,X); enable=1; store 0xDEADBEEF to 0x20 with wstrb=0xF -> no mem_valid; cpu_ready after 2 cycles; fault=1; fault_irq one pulse; op 0x7 reads 0x20; sram unchanged.
- Same config: fetch at 0x0 and load at 0x3FC -> both forwarded. Load at 0x400 (limit, exclusive) -> denied.
- Region1 base=0x100, limit=0x200, attr=0x80000002 (W), overlapping region0: store at 0x180 permitted; store at 0x80 denied.
- Two consecutive faults at 0x20 then 0x30 -> fault_addr stays 0x20. Op 0xA clears; next fault at 0x30 latches 0x30.
- Assert reset while in FWD -> mem_valid low the next cycle; no cpu_ready; all regions read back 0 via op 0x4/0x5/0x6.
